// File: rtl/mmio_responder.sv
// MMIO target for the CPU MEM stage: LED register, synchronized switches and a countdown timer.
// Optional watchdog (write-only kick at 0x30) is built when MMIO_WATCHDOG_EN is defined.
module mmio_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00,
   parameter int unsigned TIMER_W    = 16,
   parameter int unsigned WDT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  memwrite,
   input  logic        mem2reg,
   output logic [31:0] io_data,
   output logic        io_valid,
   input  logic [15:0] i_switch,
   output logic [15:0] o_led,
   output logic        cout,
   output logic        o_wreset
);

   localparam logic [9:0] OFF_LED    = 10'h000;
   localparam logic [9:0] OFF_SWITCH = 10'h010;
   localparam logic [9:0] OFF_CTRL   = 10'h020;
   localparam logic [9:0] OFF_LOAD   = 10'h024;
   localparam logic [9:0] OFF_COUNT  = 10'h028;
   localparam logic [9:0] OFF_STATUS = 10'h02C;
   localparam logic [9:0] OFF_WDT    = 10'h030;

   if (TIMER_W < 1 || TIMER_W > 32 || WDT_CYCLES < 2) begin : g_bad_cfg
      $error("mmio_responder: unsupported parameter values");
   end

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   logic [15:0]        led_q, led_d;
   logic [15:0]        sw_meta_q, sw_sync_q;
   logic               en_q, en_d, ar_q, ar_d;
   logic [TIMER_W-1:0] load_q, load_d, count_q, count_d;
   logic               expired_q, expired_d;
   logic               cout_q, cout_d;
   logic [31:0]        io_data_q, io_data_d;
   logic               io_valid_q, io_valid_d;

   logic        sel, wr_en, rd_en, ctrl_wr, status_w1c, timer_run;
   logic [9:0]  off;
   logic [31:0] rdata;

   assign sel   = (addr[31:10] == BASE_ADDR[31:10]);
   assign off   = addr[9:0];
   assign wr_en = sel && (|memwrite);
   assign rd_en = sel && mem2reg;

   always_comb begin
      led_d      = led_q;
      load_d     = load_q;
      en_d       = en_q;
      ar_d       = ar_q;
      count_d    = count_q;
      cout_d     = 1'b0;
      ctrl_wr    = wr_en && (off == OFF_CTRL) && memwrite[0];
      status_w1c = wr_en && (off == OFF_STATUS) && memwrite[0] && wdata[0];
      expired_d  = expired_q && !status_w1c;
      // A CTRL write that clears enable freezes COUNT on this very edge.
      timer_run  = en_q && !(ctrl_wr && !wdata[0]);

      if (wr_en && off == OFF_LED)
         led_d = 16'(merge_lanes({16'h0000, led_q}, wdata, memwrite));
      if (wr_en && off == OFF_LOAD)
         load_d = TIMER_W'(merge_lanes(32'(load_q), wdata, memwrite));

      if (timer_run) begin
         if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
            if (count_q == TIMER_W'(1)) begin
               cout_d    = 1'b1;
               expired_d = 1'b1;
            end
         end else if (ar_q && load_q != '0) begin
            count_d = load_q;
         end else begin
            en_d = 1'b0;
         end
      end

      if (ctrl_wr) begin
         en_d = wdata[0];
         ar_d = wdata[1];
         if (wdata[0] && !en_q) count_d = load_q;
      end

      // Reads use pre-edge register values, so a same-cycle write is not visible.
      rdata = 32'h0;
      case (off)
         OFF_LED:    rdata = {16'h0000, led_q};
         OFF_SWITCH: rdata = {16'h0000, sw_sync_q};
         OFF_CTRL:   rdata = {30'h0, ar_q, en_q};
         OFF_LOAD:   rdata = 32'(load_q);
         OFF_COUNT:  rdata = 32'(count_q);
         OFF_STATUS: rdata = {31'h0, expired_q};
         default:    rdata = 32'h0;
      endcase
      io_valid_d = rd_en;
      io_data_d  = rd_en ? rdata : io_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q      <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         en_q       <= 1'b0;
         ar_q       <= 1'b0;
         load_q     <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         cout_q     <= 1'b0;
         io_data_q  <= '0;
         io_valid_q <= 1'b0;
      end else begin
         led_q      <= led_d;
         sw_meta_q  <= i_switch;
         sw_sync_q  <= sw_meta_q;
         en_q       <= en_d;
         ar_q       <= ar_d;
         load_q     <= load_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         cout_q     <= cout_d;
         io_data_q  <= io_data_d;
         io_valid_q <= io_valid_d;
      end
   end

   assign o_led    = led_q;
   assign cout     = cout_q;
   assign io_data  = io_data_q;
   assign io_valid = io_valid_q;

`ifdef MMIO_WATCHDOG_EN
   localparam int unsigned       WDT_W    = $clog2(WDT_CYCLES) + 1;
   localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic [2:0]       wrst_cnt_q, wrst_cnt_d;

   // wrst_cnt counts down the 4-cycle reset request after a timeout.
   always_comb begin
      wrst_cnt_d = (wrst_cnt_q != 3'd0) ? wrst_cnt_q - 3'd1 : 3'd0;
      if (wr_en && off == OFF_WDT) begin
         wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_LAST) begin
         wdt_cnt_d  = '0;
         wrst_cnt_d = 3'd4;
      end else begin
         wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt_q  <= '0;
         wrst_cnt_q <= '0;
      end else begin
         wdt_cnt_q  <= wdt_cnt_d;
         wrst_cnt_q <= wrst_cnt_d;
      end
   end

   assign o_wreset = (wrst_cnt_q != 3'd0);
`else
   assign o_wreset = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder: LED lanes, switch sync, timer modes, reset.
module tb_mmio_responder;

`ifdef MMIO_WATCHDOG_EN
   localparam int unsigned WDT_TB = 16;
`else
   localparam int unsigned WDT_TB = 65536;
`endif

   localparam logic [31:0] A_LED    = 32'hFFFF_FC00;
   localparam logic [31:0] A_SWITCH = 32'hFFFF_FC10;
   localparam logic [31:0] A_CTRL   = 32'hFFFF_FC20;
   localparam logic [31:0] A_LOAD   = 32'hFFFF_FC24;
   localparam logic [31:0] A_COUNT  = 32'hFFFF_FC28;
   localparam logic [31:0] A_STATUS = 32'hFFFF_FC2C;
   localparam logic [31:0] A_WDT    = 32'hFFFF_FC30;

   logic        clk, rst;
   logic [31:0] addr, wdata, io_data;
   logic [3:0]  memwrite;
   logic        mem2reg, io_valid, cout, o_wreset;
   logic [15:0] i_switch, o_led;

   int n_checks;
   int n_fail;

   mmio_responder #(.WDT_CYCLES(WDT_TB)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .memwrite(memwrite),
      .mem2reg(mem2reg), .io_data(io_data), .io_valid(io_valid),
      .i_switch(i_switch), .o_led(o_led), .cout(cout), .o_wreset(o_wreset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic rd);
      addr     = a;
      wdata    = d;
      memwrite = be;
      mem2reg  = rd;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      drive(a, d, be, 1'b0);
      tick();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      drive(a, 32'h0, 4'h0, 1'b1);
      tick();
      idle();
      check_eq({tag, "_vld"}, {31'h0, io_valid}, 32'h1);
      check_eq(tag, io_data, exp);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      i_switch = 16'h0000;
      idle();
      tick();
      check_eq("rst_led", {16'h0, o_led}, 32'h0);
      check_eq("rst_io_data", io_data, 32'h0);
      check_eq("rst_io_valid", {31'h0, io_valid}, 32'h0);
      check_eq("rst_cout", {31'h0, cout}, 32'h0);
      check_eq("rst_wreset", {31'h0, o_wreset}, 32'h0);
      rst = 1'b0;

      // LED byte lanes, upper lanes ignored, out-of-window write dropped
      wr(A_LED, 32'h1234_ABCD, 4'b0001);
      check_eq("led_lane0", {16'h0, o_led}, 32'h0000_00CD);
      wr(A_LED, 32'h1234_ABCD, 4'b0010);
      check_eq("led_lane1", {16'h0, o_led}, 32'h0000_ABCD);
      wr(A_LED, 32'hFFFF_FFFF, 4'b1100);
      check_eq("led_upper_lanes", {16'h0, o_led}, 32'h0000_ABCD);
      wr(32'h0000_0000, 32'h0000_FFFF, 4'b0011);
      check_eq("led_unselected", {16'h0, o_led}, 32'h0000_ABCD);
      rd_chk("led_read", A_LED, 32'h0000_ABCD);

      // same-cycle read and write returns the pre-write value
      drive(A_LED, 32'h0000_5A5A, 4'b0011, 1'b1);
      tick();
      idle();
      check_eq("rw_same_old", io_data, 32'h0000_ABCD);
      check_eq("rw_same_led", {16'h0, o_led}, 32'h0000_5A5A);

      // switch synchronizer: held read sees the change on the third edge
      i_switch = 16'h00F0;
      drive(A_SWITCH, 32'h0, 4'h0, 1'b1);
      tick();
      tick();
      check_eq("sw_edge2", io_data, 32'h0);
      tick();
      check_eq("sw_edge3", io_data, 32'h0000_00F0);
      idle();
      drive(32'h0000_0010, 32'h0, 4'h0, 1'b1);
      tick();
      idle();
      check_eq("unsel_vld", {31'h0, io_valid}, 32'h0);
      check_eq("unsel_hold", io_data, 32'h0000_00F0);
      rd_chk("unmapped_14", 32'hFFFF_FC14, 32'h0);
      wr(32'hFFFF_FC40, 32'hFFFF_FFFF, 4'hF);
      rd_chk("unmapped_40", 32'hFFFF_FC40, 32'h0);
`ifndef MMIO_WATCHDOG_EN
      wr(A_WDT, 32'h1, 4'hF);
      rd_chk("wdt_absent", A_WDT, 32'h0);
      check_eq("wdt_tied", {31'h0, o_wreset}, 32'h0);
`endif

      // one-shot: LOAD=3 -> COUNT 3,2,1,0, cout at the 1->0 step
      wr(A_LOAD, 32'h3, 4'b0011);
      wr(A_CTRL, 32'h1, 4'b0001);
      drive(A_COUNT, 32'h0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq($sformatf("oneshot_count%0d", i), io_data, 32'(3 - i));
         check_eq($sformatf("oneshot_cout%0d", i), {31'h0, cout}, (i == 2) ? 32'h1 : 32'h0);
      end
      idle();
      rd_chk("oneshot_status", A_STATUS, 32'h1);
      rd_chk("oneshot_ctrl", A_CTRL, 32'h0);

      // auto-reload: LOAD=2 -> cout every third cycle; expiry beats clear
      wr(A_STATUS, 32'h1, 4'b0001);
      wr(A_LOAD, 32'h2, 4'b0011);
      wr(A_CTRL, 32'h3, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("reload_cout%0d", i), {31'h0, cout},
                  (i == 1 || i == 4) ? 32'h1 : 32'h0);
      end
      wr(A_STATUS, 32'h1, 4'b0001);
      check_eq("reload_cout5", {31'h0, cout}, 32'h0);
      rd_chk("status_cleared", A_STATUS, 32'h0);
      wr(A_STATUS, 32'h1, 4'b0001);
      check_eq("reload_cout7", {31'h0, cout}, 32'h1);
      rd_chk("status_set_wins", A_STATUS, 32'h1);
      wr(A_CTRL, 32'h0, 4'b0001);
      rd_chk("freeze_a", A_COUNT, 32'h2);
      rd_chk("freeze_b", A_COUNT, 32'h2);

      // reset in the middle of a countdown
      wr(A_LOAD, 32'h5, 4'b0011);
      wr(A_CTRL, 32'h1, 4'b0001);
      drive(A_COUNT, 32'h0, 4'h0, 1'b1);
      tick();
      tick();
      tick();
      check_eq("pre_rst_count", io_data, 32'h3);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_led", {16'h0, o_led}, 32'h0);
      check_eq("midrst_io_data", io_data, 32'h0);
      check_eq("midrst_io_valid", {31'h0, io_valid}, 32'h0);
      check_eq("midrst_cout", {31'h0, cout}, 32'h0);
      rd_chk("midrst_count", A_COUNT, 32'h0);
      rd_chk("midrst_load", A_LOAD, 32'h0);

      // enable with LOAD=0: no expiry, enable drops by itself
      wr(A_CTRL, 32'h1, 4'b0001);
      check_eq("load0_cout_a", {31'h0, cout}, 32'h0);
      tick();
      check_eq("load0_cout_b", {31'h0, cout}, 32'h0);
      rd_chk("load0_ctrl", A_CTRL, 32'h0);
      rd_chk("load0_status", A_STATUS, 32'h0);

`ifdef MMIO_WATCHDOG_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check_eq($sformatf("wdt_nokick%0d", k), {31'h0, o_wreset},
                  (k >= 16 && k <= 19) ? 32'h1 : 32'h0);
      end
      begin
         logic seen_high;
         seen_high = 1'b0;
         for (int k = 1; k <= 60; k++) begin
            if (k % 10 == 0) drive(A_WDT, 32'h1, 4'hF, 1'b0);
            else idle();
            tick();
            seen_high = seen_high | o_wreset;
         end
         idle();
         check_eq("wdt_kicked", {31'h0, seen_high}, 32'h0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder: the target end of the CPU's MEM-stage load/store interface.
- Decodes CPU accesses to the I/O window and returns read data on `io_data`.
- Holds the LED output register, a synchronized switch input and a countdown timer.
- Sits beside data memory; the CPU MEM stage drives address, write data, byte-lane write enables and a read strobe.

Parameters:
- BASE_ADDR, 32'hFFFF_FC00: I/O window base; window is 1 KiB, selected by addr[31:10] == BASE_ADDR[31:10].
- TIMER_W, 16: timer counter and load register width.
- WDT_CYCLES, 65536: watchdog timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr  in  32  byte address from the CPU MEM stage (alu_out)
- wdata  in  32  store data from the CPU MEM stage
- memwrite  in  4  byte-lane write enables; bit i writes wdata[8i+7:8i]
- mem2reg  in  1  load strobe
- io_data  out  32  read data returned to the CPU
- io_valid  out  1  io_data is valid this cycle
- i_switch  in  16  asynchronous switch inputs
- o_led  out  16  LED register
- cout  out  1  one-cycle timer-expiry pulse
- o_wreset  out  1  watchdog reset request (optional feature)

Behaviour:
- Reset: every register clears on the first clk edge with rst=1. Reset values: o_led=0, io_data=0, io_valid=0, cout=0, o_wreset=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, switch synchronizer=0.
- sel = (addr[31:10] == BASE_ADDR[31:10]). Offset = addr[9:0]. Accesses with sel=0 are ignored: no writes, io_valid=0.
- Register map (offset, access, contents):
  - 0x00 LED, RW: 16 bits.
  - 0x10 SWITCH, RO: two-flop synchronized i_switch.
  - 0x20 CTRL, RW: bit0 enable, bit1 auto_reload.
  - 0x24 LOAD, RW: TIMER_W bits.
  - 0x28 COUNT, RO.
  - 0x2C STATUS: bit0 expired, sticky; write 1 to clear.
  - 0x30 WDT: write-only kick (optional feature).
- Unmapped offsets: read 0, writes dropped.
- Writes: a register is written when sel is true and any memwrite bit is set. Only byte lanes with an enable bit set are updated. Lanes above a register's width are ignored.
- Reads:
  - One-cycle latency. If sel & mem2reg at edge N, then io_data holds the register value and io_valid=1 after edge N+1.
  - Otherwise io_valid=0 and io_data holds its last value.
  - Read and write of the same register in the same cycle returns the pre-write value.
  - Read bits above a register's width are 0.
- Timer:
  - Writing CTRL with bit0=1 while enable was 0 copies LOAD into COUNT.
  - While enable=1 and COUNT != 0: COUNT decrements by 1 each cycle.
  - On the 1→0 step: set STATUS.expired, pulse cout for exactly one cycle. Then, if auto_reload=1, the next cycle loads COUNT from LOAD; else enable clears to 0.
  - Enable with LOAD=0: COUNT=0, no expiry, no cout, enable clears the following cycle.
  - Writing LOAD while running does not touch COUNT; it takes effect on the next reload.
  - Writing CTRL bit0=0 freezes COUNT.
- Same-cycle events:
  - Expiry and a STATUS write-1-clear in the same cycle: set wins, expired stays 1.
  - rst asserted mid-countdown: all state returns to reset values on that edge.
- Synchronizer: SWITCH reflects an i_switch change after 2 edges; a read issued in that cycle sees it 3 edges after the change.

Optional Feature:
- Macro: MMIO_WATCHDOG_EN.
- When defined:
  - A watchdog counter of width clog2(WDT_CYCLES)+1 increments every cycle.
  - Any write to offset 0x30 clears it.
  - When it reaches WDT_CYCLES-1, o_wreset is held 1 for exactly 4 cycles and the counter restarts from 0.
  - rst clears both the counter and o_wreset.
- When undefined: no watchdog logic, o_wreset tied 0, writes to 0x30 dropped, reads of 0x30 return 0.

Test Plan:
- rst=1 one cycle, then write 0xFFFF_FC00, wdata=0x1234_ABCD, memwrite=4'b0001 → o_led=0x00CD next cycle. Then memwrite=4'b0010 → o_led=0xABCD.
- i_switch=0x00F0, then read 0xFFFF_FC10 → io_data=0x0000_00F0 with io_valid=1 at most 3 edges after the change. Read 0xFFFF_FC14 → io_data=0, io_valid=1. Read 0x0000_0010 → io_valid=0.
- LOAD=3, CTRL=0x1 → COUNT reads 3,2,1,0 on consecutive cycles. cout=1 for exactly one cycle at the 0 step. STATUS=1, CTRL bit0 reads 0 afterwards.
- LOAD=2, CTRL=0x3 → cout pulses every 3 cycles (count 2,1,0, reload). Writing STATUS=1 in the same cycle as an expiry leaves STATUS=1.
- Countdown with LOAD=5, rst asserted at COUNT=2 → all outputs 0 next cycle. LOAD=0 with CTRL=0x1 → no cout, CTRL reads 0.
- With MMIO_WATCHDOG_EN and WDT_CYCLES=16: no kick → o_wreset high for 4 cycles starting 16 cycles after reset. Kick every 10 cycles → o_wreset stays 0.
